// File: rtl/adder_acc_pkg.sv
// Shared types and constants for the adder_accumulator sequencer.
package adder_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned ACC_WIDTH_DEFAULT = 4;
  localparam logic [ACC_WIDTH_DEFAULT-1:0] ACC_ZERO = '0;

endpackage

// File: rtl/adder_accumulator.sv
// Sequencer and state around an external combinational ripple adder.
// Optional clamp-on-overflow behaviour: define ADDER_ACC_SATURATE_EN.
module adder_accumulator
  import adder_acc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_clear,
  input  logic [WIDTH-1:0] in_operand,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] acc,
  output logic             carry_sticky,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [WIDTH-1:0] ACC_CLEAR = WIDTH'(ACC_ZERO);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] add_b_reg, add_b_next;
  logic             add_cin_reg, add_cin_next;
  logic             sticky_reg, sticky_next;
  logic [WIDTH-1:0] sum_value;

`ifdef ADDER_ACC_SATURATE_EN
  assign sum_value = add_cout ? {WIDTH{1'b1}} : add_sum;
`else
  assign sum_value = add_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= ACC_CLEAR;
      add_b_reg   <= '0;
      add_cin_reg <= 1'b0;
      sticky_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      add_b_reg   <= add_b_next;
      add_cin_reg <= add_cin_next;
      sticky_reg  <= sticky_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    add_b_next   = add_b_reg;
    add_cin_next = add_cin_reg;
    sticky_next  = sticky_reg;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_clear) begin
            acc_next    = ACC_CLEAR;
            sticky_next = 1'b0;
            state_next  = RESP;
          end else begin
            add_b_next   = in_operand;
            add_cin_next = in_cin;
            state_next   = SUM;
          end
        end
      end
      SUM: begin
        // The adder has had the whole cycle to settle on acc/add_b/add_cin.
        acc_next    = sum_value;
        sticky_next = sticky_reg | add_cout;
        state_next  = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign add_a        = acc_reg;
  assign add_b        = add_b_reg;
  assign add_cin      = add_cin_reg;
  assign acc          = acc_reg;
  assign carry_sticky = sticky_reg;

endmodule

// File: tb/tb_adder_accumulator.sv
// Scoreboard bench for adder_accumulator with a behavioural adder and model.
module tb_adder_accumulator;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_clear = 1'b0;
  logic [W-1:0] in_operand = '0;
  logic         in_cin = 1'b0;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic [W-1:0] acc;
  logic         carry_sticky;
  logic         out_valid;
  logic         out_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [W-1:0] acc;
    logic         sticky;
    int           accept_cyc;
    int           lat;
  } exp_t;
  exp_t exp_q[$];

  int  model_acc = 0;
  bit  model_sticky = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder attached at the parent level
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  adder_accumulator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_clear(in_clear),
    .in_operand(in_operand), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .acc(acc), .carry_sticky(carry_sticky),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(string name, int actual, int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake
  bit prev_valid = 1'b0;
  int valid_rise = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      check("add_a_tracks_acc", add_a, acc);
      if (prev_valid && !out_valid) check("out_valid_dropped", 0, 1);
      if (out_valid && !prev_valid) valid_rise = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_acc", acc, e.acc);
          check("result_sticky", carry_sticky, e.sticky);
          check("result_latency", valid_rise - e.accept_cyc, e.lat);
          $display("result acc=%h sticky=%0d latency=%0d", acc, carry_sticky,
                   valid_rise - e.accept_cyc);
        end
      end
      prev_valid = out_valid && !out_ready;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(bit clr, logic [W-1:0] op, bit ci);
    int n = 0;
    int sum;
    exp_t e;
    in_valid = 1'b1; in_clear = clr; in_operand = op; in_cin = ci;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      if (clr) begin
        model_acc = 0; model_sticky = 1'b0; e.lat = 1;
      end else begin
        sum = model_acc + int'(op) + int'(ci);
        if (sum >= (1 << W)) model_sticky = 1'b1;
`ifdef ADDER_ACC_SATURATE_EN
        model_acc = (sum >= (1 << W)) ? (1 << W) - 1 : sum;
`else
        model_acc = sum % (1 << W);
`endif
        e.lat = 2;
      end
      e.acc = W'(model_acc); e.sticky = model_sticky; e.accept_cyc = cyc;
      exp_q.push_back(e);
      $display("issue clear=%0d op=%h cin=%0d -> expect acc=%h sticky=%0d",
               clr, op, ci, e.acc, e.sticky);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_clear = 1'($urandom); in_operand = W'($urandom); in_cin = 1'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("drain_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_acc", acc, 0);
    check("reset_sticky", carry_sticky, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_add_b", add_b, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);

    // Clear, +3, +4 with carry-in
    issue(1'b1, 4'h0, 1'b0);
    issue(1'b0, 4'h3, 1'b0);
    issue(1'b0, 4'h4, 1'b1);
    wait_drain();
    check("acc_after_3_plus_5", acc, 8);

    // Overflow from 0xE
    issue(1'b1, 4'h0, 1'b0);
    issue(1'b0, 4'hE, 1'b0);
    issue(1'b0, 4'h3, 1'b0);
    wait_drain();
`ifdef ADDER_ACC_SATURATE_EN
    check("overflow_acc", acc, 4'hF);
`else
    check("overflow_acc", acc, 4'h1);
`endif
    check("overflow_sticky", carry_sticky, 1);

    // Consumer stall for 5 cycles; new commands must be ignored
    out_ready = 1'b0;
    issue(1'b0, 4'h2, 1'b0);
    begin
      int n = 0;
      while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_clear = 1'b1; in_operand = W'($urandom); in_cin = 1'($urandom);
      check("stall_acc", acc, model_acc);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(1'b1, 4'h0, 1'b0);   // held request accepted once IDLE returns
    wait_drain();

    // Reset while in SUM aborts the add
    issue(1'b0, 4'h7, 1'b1);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    model_acc = 0; model_sticky = 1'b0;
    #1;
    check("abort_acc", acc, 0);
    check("abort_sticky", carry_sticky, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_add_b", add_b, 0);
    check("abort_add_cin", add_cin, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_valid", out_valid, 0);
      @(posedge clk); #1;
    end

    // Clear after an overflow
    issue(1'b0, 4'hF, 1'b0);
    issue(1'b0, 4'h1, 1'b0);
    issue(1'b1, 4'h0, 1'b0);
    wait_drain();
    check("clear_after_ovf_sticky", carry_sticky, 0);

    // Randomised traffic with random consumer back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue($urandom_range(0, 7) == 0, W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
